// File: rtl/async_fifo_pkg.sv
// Pointer encoding helpers shared by the read- and write-side FIFO controllers.
// Both functions take and return PTR_MAX_W-bit values. Callers zero-extend a
// narrower pointer on the way in and truncate the result back to their own
// pointer width. Zero upper bits leave the Gray/binary conversion unchanged,
// so one function body works for any pointer width up to PTR_MAX_W.
package async_fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] ptr);
    return ptr ^ (ptr >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] ptr);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = ptr[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ ptr[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser chain with async active-low reset to zero.
// Ports: clk, rst_n, d_i (async input bus), q_o (output of the last stage).
module sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Flop chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer and flag control for the async FIFO, in the rclk domain.
// Ports:
//   rclk, rd_rstn  - read clock, async active-low reset
//   rd_en          - read request
//   rd_flush       - one-cycle request to discard all visible data
//   wgray_in       - write Gray pointer from the wclk domain (unsynchronised)
//   rd_addr        - RAM read address
//   rgray_out      - registered Gray read pointer, for the write domain
//   empty          - registered empty flag
//   almost_empty   - registered, set when level <= AE_THRESH
//   rd_level       - registered occupancy seen from the read side
//   rd_fire        - combinational RAM read strobe (rd_en && !empty)
//   underflow      - registered pulse: previous cycle had rd_en while empty
module rd_ptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic              rclk,
  input  logic              rd_rstn,
  input  logic              rd_en,
  input  logic              rd_flush,
  input  logic [ADDR_W:0]   wgray_in,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rgray_out,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_fire,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wgray_s;
  logic [PTR_W-1:0] wbin_s;

  logic [PTR_W-1:0] rbin_q,  rbin_d;
  logic [PTR_W-1:0] rgray_q, rgray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             ae_q,    ae_d;
  logic             uf_q,    uf_d;

  // Bring the write pointer into rclk.
  sync_ff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wgray_sync (
    .clk   (rclk),
    .rst_n (rd_rstn),
    .d_i   (wgray_in),
    .q_o   (wgray_s)
  );

  assign wbin_s  = PTR_W'(gray2bin(PTR_MAX_W'(wgray_s)));
  assign rd_fire = rd_en && !empty_q;

  // Next pointer and flags. Flags come from the next-state pointer so that
  // reading the last word shows empty on the very next cycle.
  always_comb begin
    rbin_d = rbin_q;
    if (rd_flush) begin
      rbin_d = wbin_s;
    end else if (rd_fire) begin
      rbin_d = rbin_q + PTR_W'(1);
    end
    rgray_d = PTR_W'(bin2gray(PTR_MAX_W'(rbin_d)));
    empty_d = (rgray_d == wgray_s);
    level_d = wbin_s - rbin_d;
    ae_d    = (level_d <= PTR_W'(AE_THRESH));
    uf_d    = rd_en && empty_q && !rd_flush;
  end

  // State registers.
  always_ff @(posedge rclk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uf_q    <= uf_d;
    end
  end

  assign rd_addr      = rbin_q[ADDR_W-1:0];
  assign rgray_out    = rgray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = level_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed bench for rd_ptr_ctrl (ADDR_W=3, SYNC_STAGES=2, AE_THRESH=2).
module tb_rd_ptr_ctrl;

  logic       rclk;
  logic       rd_rstn;
  logic       rd_en;
  logic       rd_flush;
  logic [3:0] wgray_in;
  logic [2:0] rd_addr;
  logic [3:0] rgray_out;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       rd_fire;
  logic       underflow;

  rd_ptr_ctrl #(
    .ADDR_W      (3),
    .SYNC_STAGES (2),
    .AE_THRESH   (2)
  ) dut (
    .rclk         (rclk),
    .rd_rstn      (rd_rstn),
    .rd_en        (rd_en),
    .rd_flush     (rd_flush),
    .wgray_in     (wgray_in),
    .rd_addr      (rd_addr),
    .rgray_out    (rgray_out),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .rd_fire      (rd_fire),
    .underflow    (underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%0h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic check_flags(input logic e_empty, input logic e_ae,
                             input logic [3:0] e_lvl, input logic e_uf);
    push("empty", 32'(e_empty));
    push("almost_empty", 32'(e_ae));
    push("rd_level", 32'(e_lvl));
    push("underflow", 32'(e_uf));
    pop_chk(32'(empty));
    pop_chk(32'(almost_empty));
    pop_chk(32'(rd_level));
    pop_chk(32'(underflow));
  endtask

  task automatic check_ptr(input logic [3:0] rb);
    push("rd_addr", 32'(rb[2:0]));
    push("rgray_out", 32'(g(rb)));
    pop_chk(32'(rd_addr));
    pop_chk(32'(rgray_out));
  endtask

  task automatic check_fire(input logic e);
    push("rd_fire", 32'(e));
    pop_chk(32'(rd_fire));
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  logic [3:0] rb;
  logic [3:0] wb;
  logic [3:0] prev_g;

  initial begin
    rd_rstn  = 1'b0;
    rd_en    = 1'b0;
    rd_flush = 1'b0;
    wgray_in = '0;
    rb       = '0;
    wb       = '0;
    prev_g   = '0;

    // Reset state
    repeat (2) tick();
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    check_ptr(4'd0);
    rd_rstn = 1'b1;
    repeat (2) tick();
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    check_ptr(4'd0);

    // Five writes become visible on the third edge
    wb = 4'd5;
    wgray_in = g(wb);
    tick();
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    tick();
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    tick();
    check_flags(1'b0, 1'b0, 4'd5, 1'b0);

    // Drain them; almost_empty rises at level 2, empty after the fifth
    for (int k = 0; k < 5; k++) begin
      rd_en = 1'b1;
      #1;
      check_fire(1'b1);
      check_ptr(rb);
      tick();
      rb = rb + 4'd1;
      check_flags(k == 4, (4 - k) <= 2, 4'(4 - k), 1'b0);
    end

    // Reads while empty: pointer holds, underflow one cycle later
    for (int k = 0; k < 3; k++) begin
      #1;
      check_fire(1'b0);
      check_ptr(rb);
      tick();
      check_flags(1'b1, 1'b1, 4'd0, 1'b1);
    end
    rd_en = 1'b0;
    tick();
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    check_ptr(4'd5);

    // Two full bursts of eight; the second read pass wraps rbin 15 -> 0
    for (int b = 0; b < 2; b++) begin
      wb = wb + 4'd8;
      wgray_in = g(wb);
      repeat (3) tick();
      check_flags(1'b0, 1'b0, 4'd8, 1'b0);
      for (int k = 0; k < 8; k++) begin
        rd_en  = 1'b1;
        prev_g = rgray_out;
        #1;
        check_fire(1'b1);
        check_ptr(rb);
        tick();
        rb = rb + 4'd1;
        check_ptr(rb);
        push("rgray_one_bit", 32'd1);
        pop_chk(32'($countones(prev_g ^ rgray_out) == 1));
        push("level_le_8", 32'd1);
        pop_chk(32'(rd_level <= 4'd8));
        check_flags(k == 7, (7 - k) <= 2, 4'(7 - k), 1'b0);
      end
      rd_en = 1'b0;
    end

    // Flush with rd_en at level 6
    wb = wb + 4'd6;
    wgray_in = g(wb);
    repeat (3) tick();
    check_flags(1'b0, 1'b0, 4'd6, 1'b0);
    rd_flush = 1'b1;
    rd_en    = 1'b1;
    tick();
    rb = wb;
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    check_ptr(rb);
    // Flush while empty with rd_en: still no underflow
    tick();
    rd_flush = 1'b0;
    rd_en    = 1'b0;
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    check_ptr(rb);

    // Asynchronous reset mid-run clears everything before any edge
    wb = wb + 4'd3;
    wgray_in = g(wb);
    repeat (3) tick();
    check_flags(1'b0, 1'b0, 4'd3, 1'b0);
    rd_rstn = 1'b0;
    #2;
    check_flags(1'b1, 1'b1, 4'd0, 1'b0);
    check_ptr(4'd0);
    tick();
    rd_rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
